// File: rtl/univ_reg_n.sv
// Universal N-bit register: shift/rotate/load plus modulo-(MAX_COUNT+1) up/down counter.
// Latency 1 clk to q/c_out (so_r/so_l are combinational taps); no backpressure, en=0 simply holds.
module univ_reg_n #(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_par,
  input  logic             msb_i,
  input  logic             lsb_i,
  output logic [WIDTH-1:0] q,
  output logic             c_out,
  output logic             so_r,
  output logic             so_l
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_UP    = 3'b100;
  localparam logic [2:0] MODE_DOWN  = 3'b101;
  localparam logic [2:0] MODE_ROR   = 3'b110;
  localparam logic [2:0] MODE_ROL   = 3'b111;

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

  logic [WIDTH-1:0] q_nxt;
  logic             c_nxt;

  always_comb begin
    q_nxt = q;
    c_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: q_nxt = q;
        MODE_SHR:  q_nxt = {msb_i, q[WIDTH-1:1]};
        MODE_SHL:  q_nxt = {q[WIDTH-2:0], lsb_i};
        MODE_LOAD: q_nxt = d_par;
        // >= rather than == so an out-of-range load wraps on the next up-count
        MODE_UP: begin
          if (q >= MAX_Q) begin
            q_nxt = '0;
            c_nxt = 1'b1;
          end else begin
            q_nxt = q + ONE_Q;
          end
        end
        MODE_DOWN: begin
          if (q == '0) begin
            q_nxt = MAX_Q;
            c_nxt = 1'b1;
          end else begin
            q_nxt = q - ONE_Q;
          end
        end
        MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
        MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        default:   q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q     <= '0;
      c_out <= 1'b0;
    end else begin
      q     <= q_nxt;
      c_out <= c_nxt;
    end
  end

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_reg_n.sv
// Directed-vector bench for univ_reg_n as a 4-bit decade counter / shifter.
module tb_univ_reg_n;

  localparam int          WIDTH     = 4;
  localparam int unsigned MAX_COUNT = 9;

  if (MAX_COUNT > (1 << WIDTH) - 1) begin : g_bad_max
    $fatal(1, "MAX_COUNT exceeds 2^WIDTH-1");
  end

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d_par;
  logic             msb_i;
  logic             lsb_i;
  logic [WIDTH-1:0] q;
  logic             c_out;
  logic             so_r;
  logic             so_l;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  univ_reg_n #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) dut (
    .clk   (clk),
    .clear (clear),
    .en    (en),
    .mode  (mode),
    .d_par (d_par),
    .msb_i (msb_i),
    .lsb_i (lsb_i),
    .q     (q),
    .c_out (c_out),
    .so_r  (so_r),
    .so_l  (so_l)
  );

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] val);
    en    = 1'b1;
    mode  = 3'b011;
    d_par = val;
    tick();
    vecs++;
    if (q !== val || c_out !== 1'b0) begin
      errs++;
      $display("FAIL load: q=%h c_out=%b, expected q=%h c_out=0", q, c_out, val);
    end
  endtask

  task automatic test_reset();
    en    = 1'b1;
    mode  = 3'b011;
    d_par = 4'h6;
    #2 clear = 1'b0;
    #1;
    vecs++;
    if (q !== 4'h0 || c_out !== 1'b0) begin
      errs++;
      $display("FAIL reset_async: q=%h c_out=%b, expected q=0 c_out=0", q, c_out);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if (q !== 4'h0 || c_out !== 1'b0 || so_r !== 1'b0 || so_l !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold[%0d]: q=%h c_out=%b so_r=%b so_l=%b, expected all 0",
                 i, q, c_out, so_r, so_l);
      end
    end
    clear = 1'b1;
    tick();
    vecs++;
    if (q !== 4'h6 || c_out !== 1'b0) begin
      errs++;
      $display("FAIL reset_then_load: q=%h c_out=%b, expected q=6 c_out=0", q, c_out);
    end
  endtask

  task automatic test_decade_wrap();
    logic [3:0] exp_q [7];
    logic       exp_c [7];
    logic [2:0] md    [7];
    exp_q = '{4'd8, 4'd9, 4'd0, 4'd1, 4'd0, 4'd9, 4'd8};
    exp_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    md    = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b101, 3'b101, 3'b101};
    load(4'd7);
    for (int i = 0; i < 7; i++) begin
      mode = md[i];
      tick();
      vecs++;
      if (q !== exp_q[i] || c_out !== exp_c[i]) begin
        errs++;
        $display("FAIL decade[%0d]: q=%0d c_out=%b, expected q=%0d c_out=%b",
                 i, q, c_out, exp_q[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [2:0] md    [7];
    logic       fm    [7];
    logic       fl    [7];
    logic [3:0] exp_q [7];
    // shl fill 1, shr fill 0, three rotate-rights, rotate-left, shr fill 1
    md    = '{3'b010, 3'b001, 3'b110, 3'b110, 3'b110, 3'b111, 3'b001};
    fm    = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b1};
    fl    = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0};
    exp_q = '{4'b1101, 4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b1001, 4'b1100};
    load(4'b0110);
    for (int i = 0; i < 7; i++) begin
      mode  = md[i];
      msb_i = fm[i];
      lsb_i = fl[i];
      tick();
      vecs++;
      if (q !== exp_q[i] || c_out !== 1'b0 ||
          so_r !== exp_q[i][0] || so_l !== exp_q[i][3]) begin
        errs++;
        $display("FAIL shift[%0d]: q=%b c_out=%b so_r=%b so_l=%b, expected q=%b c_out=0",
                 i, q, c_out, so_r, so_l, exp_q[i]);
      end
    end
    msb_i = 1'b0;
    lsb_i = 1'b0;
  endtask

  task automatic test_enable_hold();
    load(4'd5);
    en   = 1'b0;
    mode = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (q !== 4'd5 || c_out !== 1'b0) begin
        errs++;
        $display("FAIL en_hold[%0d]: q=%0d c_out=%b, expected q=5 c_out=0", i, q, c_out);
      end
    end
    en = 1'b1;
    tick();
    vecs++;
    if (q !== 4'd6 || c_out !== 1'b0) begin
      errs++;
      $display("FAIL en_resume: q=%0d c_out=%b, expected q=6 c_out=0", q, c_out);
    end
    mode = 3'b000;
    tick();
    vecs++;
    if (q !== 4'd6 || c_out !== 1'b0) begin
      errs++;
      $display("FAIL mode_hold: q=%0d c_out=%b, expected q=6 c_out=0", q, c_out);
    end
    // c_out must drop on the edge after a wrap even with en low
    load(4'd9);
    mode = 3'b100;
    tick();
    vecs++;
    if (q !== 4'd0 || c_out !== 1'b1) begin
      errs++;
      $display("FAIL wrap_before_hold: q=%0d c_out=%b, expected q=0 c_out=1", q, c_out);
    end
    en = 1'b0;
    tick();
    vecs++;
    if (q !== 4'd0 || c_out !== 1'b0) begin
      errs++;
      $display("FAIL cout_clear_en0: q=%0d c_out=%b, expected q=0 c_out=0", q, c_out);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    load(4'd1);
    mode = 3'b100;
    tick();
    tick();
    vecs++;
    if (q !== 4'd3) begin
      errs++;
      $display("FAIL mid_pre: q=%0d, expected q=3", q);
    end
    #2 clear = 1'b0;
    #1;
    vecs++;
    if (q !== 4'd0 || c_out !== 1'b0) begin
      errs++;
      $display("FAIL mid_async: q=%0d c_out=%b, expected q=0 c_out=0", q, c_out);
    end
    tick();
    vecs++;
    if (q !== 4'd0) begin
      errs++;
      $display("FAIL mid_held: q=%0d, expected q=0", q);
    end
    clear = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      vecs++;
      if (q !== 4'(i) || c_out !== 1'b0) begin
        errs++;
        $display("FAIL mid_resume[%0d]: q=%0d c_out=%b, expected q=%0d c_out=0", i, q, c_out, i);
      end
    end
  endtask

  task automatic test_out_of_range();
    load(4'hC);
    mode = 3'b100;
    tick();
    vecs++;
    if (q !== 4'h0 || c_out !== 1'b1) begin
      errs++;
      $display("FAIL oor_up: q=%h c_out=%b, expected q=0 c_out=1", q, c_out);
    end
    load(4'hC);
    mode = 3'b101;
    tick();
    vecs++;
    if (q !== 4'hB || c_out !== 1'b0) begin
      errs++;
      $display("FAIL oor_down: q=%h c_out=%b, expected q=B c_out=0", q, c_out);
    end
  endtask

  initial begin
    en    = 1'b0;
    mode  = 3'b000;
    d_par = '0;
    msb_i = 1'b0;
    lsb_i = 1'b0;
    test_reset();
    test_decade_wrap();
    test_shifts();
    test_enable_hold();
    test_reset_mid();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
